// File: rtl/noc_input_vc_unit.sv
// rtl/noc_input_vc_unit.sv - router input port: per-VC flit FIFOs, XY route computation, credit return
module noc_input_vc_unit #(
    parameter int FLIT_W     = 64,
    parameter int VC_NUM     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_X_W     = 2,
    parameter int ID_Y_W     = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0,
    parameter int TYPE_MSB   = 63,
    parameter int DEST_LSB   = 48,
    localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic [VC_W-1:0]          in_vc,
    output logic [VC_NUM-1:0]        credit_out,
    output logic [VC_NUM-1:0]        req_valid,
    output logic [5*VC_NUM-1:0]      req_route,
    output logic [FLIT_W*VC_NUM-1:0] req_flit,
    input  logic [VC_NUM-1:0]        grant,
    output logic                     overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [4:0] ROUTE_NA = 5'b00000;
    localparam logic [4:0] R_EAST   = 5'b00001;
    localparam logic [4:0] R_WEST   = 5'b00010;
    localparam logic [4:0] R_SOUTH  = 5'b00100;
    localparam logic [4:0] R_NORTH  = 5'b01000;
    localparam logic [4:0] R_LOCAL  = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_ACTIVE
    } vc_state_t;

    logic [VC_NUM-1:0] err;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [FLIT_W-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]     wr_ptr;
        logic [PW-1:0]     rd_ptr;
        logic [PW-1:0]     count;
        logic              empty;
        logic              full;
        logic              wr_sel;
        logic              pop;
        logic              push;
        logic              credit_q;
        logic [FLIT_W-1:0] head;
        logic [1:0]        head_type;
        logic [ID_X_W-1:0] dx;
        logic [ID_Y_W-1:0] dy;
        logic [4:0]        route_calc;
        logic [4:0]        route_q;
        logic [4:0]        route_d;
        vc_state_t         state_q;
        vc_state_t         state_d;

        assign count     = wr_ptr - rd_ptr;
        assign empty     = (wr_ptr == rd_ptr);
        assign full      = (count == PW'(FIFO_DEPTH));
        assign head      = mem[rd_ptr[AW-1:0]];
        assign head_type = head[TYPE_MSB -: 2];
        assign dx        = head[DEST_LSB +: ID_X_W];
        assign dy        = head[DEST_LSB + ID_X_W +: ID_Y_W];
        assign wr_sel    = in_valid && (in_vc == VC_W'(v));

        // Grants on an active VC dequeue; a body/tail at the head of an idle VC is a stray flit and is flushed
        assign pop  = !empty && (((state_q == ST_ACTIVE) && grant[v]) ||
                                 ((state_q == ST_IDLE) && !head_type[1]));
        // A full FIFO still accepts a write when the same cycle frees a slot
        assign push = wr_sel && (!full || pop);
        assign err[v] = (wr_sel && full && !pop) ||
                        ((state_q == ST_IDLE) && !empty && !head_type[1]);

        // Dimension-ordered XY route from the head flit destination
        always_comb begin
            route_calc = R_LOCAL;
            if (dx > ID_X_W'(CUR_X))      route_calc = R_EAST;
            else if (dx < ID_X_W'(CUR_X)) route_calc = R_WEST;
            else if (dy > ID_Y_W'(CUR_Y)) route_calc = R_SOUTH;
            else if (dy < ID_Y_W'(CUR_Y)) route_calc = R_NORTH;
        end

        // Packet FSM: wait for a head, latch its route for one cycle, hold it until the tail leaves
        always_comb begin
            state_d = state_q;
            route_d = route_q;
            case (state_q)
                ST_IDLE: begin
                    if (!empty && head_type[1]) state_d = ST_ROUTE;
                end
                ST_ROUTE: begin
                    route_d = route_calc;
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (pop && head_type[0]) begin
                        state_d = ST_IDLE;
                        route_d = ROUTE_NA;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    route_d = ROUTE_NA;
                end
            endcase
        end

        // State, route, pointers and the registered credit pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                route_q  <= ROUTE_NA;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                credit_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                route_q  <= route_d;
                credit_q <= pop;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end

        // Flit storage needs no reset; the pointers define what is valid
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[AW-1:0]] <= in_flit;
        end

        assign credit_out[v]               = credit_q;
        assign req_valid[v]                = (state_q == ST_ACTIVE) && !empty;
        assign req_route[5*v +: 5]         = route_q;
        assign req_flit[FLIT_W*v +: FLIT_W] = head;
    end

    // Sticky error flag for dropped writes and stray non-head flits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (|err) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_noc_input_vc_unit.sv
// tb/tb_noc_input_vc_unit.sv - scoreboard bench for noc_input_vc_unit
module tb_noc_input_vc_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [63:0]  in_flit = '0;
    logic [0:0]   in_vc = '0;
    logic [1:0]   credit_out;
    logic [1:0]   req_valid;
    logic [9:0]   req_route;
    logic [127:0] req_flit;
    logic [1:0]   grant = '0;
    logic         overflow;

    int total = 0;
    int bad = 0;

    logic [68:0] sb [2][$];

    noc_input_vc_unit #(
        .FLIT_W(64), .VC_NUM(2), .FIFO_DEPTH(4), .ID_X_W(2), .ID_Y_W(2),
        .CUR_X(1), .CUR_Y(1), .TYPE_MSB(63), .DEST_LSB(48)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
        .in_vc(in_vc), .credit_out(credit_out), .req_valid(req_valid),
        .req_route(req_route), .req_flit(req_flit), .grant(grant),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [1:0] t, input int dx, input int dy, input logic [47:0] pl);
        logic [63:0] f;
        f = '0;
        f[63:62] = t;
        f[49:48] = dx[1:0];
        f[51:50] = dy[1:0];
        f[47:0]  = pl;
        return f;
    endfunction

    function automatic logic [4:0] xy(input int dx, input int dy);
        if (dx > 1) return 5'b00001;
        if (dx < 1) return 5'b00010;
        if (dy > 1) return 5'b00100;
        if (dy < 1) return 5'b01000;
        return 5'b10000;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        sb[0].delete();
        sb[1].delete();
    endtask

    task automatic send(input int v, input logic [63:0] f, input logic [4:0] r, input bit acc);
        in_valid = 1'b1;
        in_flit  = f;
        in_vc    = v[0];
        step();
        in_valid = 1'b0;
        if (acc) sb[v].push_back({r, f});
    endtask

    task automatic drain(input int v, input int n);
        logic [68:0] e;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 20 && !req_valid[v]; w++) step();
            if (!req_valid[v]) begin
                check("req_timeout", 64'd0, 64'd1);
                return;
            end
            if (sb[v].size() == 0) begin
                check("sb_underrun", 64'd0, 64'd1);
                return;
            end
            e = sb[v].pop_front();
            check("flit", req_flit[v*64 +: 64], e[63:0]);
            check("route", 64'(req_route[v*5 +: 5]), 64'(e[68:64]));
            grant[v] = 1'b1;
            step();
            grant[v] = 1'b0;
            check("credit", 64'(credit_out[v]), 64'd1);
            if (e[62]) check("route_clr", 64'(req_route[v*5 +: 5]), 64'd0);
        end
    endtask

    initial begin
        logic [68:0] e;
        logic [63:0] f;

        do_reset();
        check("rst_credit", 64'(credit_out), 64'd0);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_route", 64'(req_route), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        grant = 2'b10;
        step();
        grant = 2'b00;
        check("ign_grant_credit", 64'(credit_out), 64'd0);

        send(0, mk(2'b11, 2, 1, 48'h1111), xy(2, 1), 1'b1);
        check("lat_t0", 64'(req_valid[0]), 64'd0);
        step();
        check("lat_t1", 64'(req_valid[0]), 64'd0);
        step();
        check("lat_t2", 64'(req_valid[0]), 64'd1);
        check("east", 64'(req_route[4:0]), 64'b00001);
        drain(0, 1);
        step();
        check("credit_once", 64'(credit_out[0]), 64'd0);
        check("idle_valid", 64'(req_valid[0]), 64'd0);

        send(1, mk(2'b10, 0, 1, 48'h2001), xy(0, 1), 1'b1);
        send(1, mk(2'b00, 0, 1, 48'h2002), xy(0, 1), 1'b1);
        send(1, mk(2'b00, 0, 1, 48'h2003), xy(0, 1), 1'b1);
        send(1, mk(2'b01, 0, 1, 48'h2004), xy(0, 1), 1'b1);
        drain(1, 4);
        check("vc1_empty", 64'(req_valid[1]), 64'd0);

        send(0, mk(2'b11, 1, 1, 48'h3001), xy(1, 1), 1'b1);
        drain(0, 1);
        send(0, mk(2'b11, 1, 3, 48'h3002), xy(1, 3), 1'b1);
        drain(0, 1);
        send(0, mk(2'b11, 1, 0, 48'h3003), xy(1, 0), 1'b1);
        drain(0, 1);
        check("dir_ovf", 64'(overflow), 64'd0);

        do_reset();
        send(0, mk(2'b10, 3, 1, 48'h4001), xy(3, 1), 1'b1);
        send(0, mk(2'b00, 3, 1, 48'h4002), xy(3, 1), 1'b1);
        send(0, mk(2'b00, 3, 1, 48'h4003), xy(3, 1), 1'b1);
        send(0, mk(2'b01, 3, 1, 48'h4004), xy(3, 1), 1'b1);
        check("pre_ovf", 64'(overflow), 64'd0);
        send(0, mk(2'b11, 0, 0, 48'h4005), xy(0, 0), 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
        drain(0, 4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        step();
        check("ovf_drained", 64'(req_valid[0]), 64'd0);

        do_reset();
        send(0, mk(2'b10, 2, 2, 48'h5001), xy(2, 2), 1'b1);
        send(0, mk(2'b00, 2, 2, 48'h5002), xy(2, 2), 1'b1);
        send(0, mk(2'b00, 2, 2, 48'h5003), xy(2, 2), 1'b1);
        send(0, mk(2'b00, 2, 2, 48'h5004), xy(2, 2), 1'b1);
        for (int w = 0; w < 20 && !req_valid[0]; w++) step();
        check("full_valid", 64'(req_valid[0]), 64'd1);
        e = sb[0].pop_front();
        check("full_head", req_flit[63:0], e[63:0]);
        f = mk(2'b01, 2, 2, 48'h5005);
        in_valid = 1'b1;
        in_flit  = f;
        in_vc    = 1'b0;
        grant[0] = 1'b1;
        step();
        in_valid = 1'b0;
        grant[0] = 1'b0;
        sb[0].push_back({xy(2, 2), f});
        check("full_credit", 64'(credit_out[0]), 64'd1);
        check("full_ovf", 64'(overflow), 64'd0);
        drain(0, 4);
        step();
        check("full_empty", 64'(req_valid[0]), 64'd0);
        check("full_ovf_end", 64'(overflow), 64'd0);

        send(0, mk(2'b10, 2, 1, 48'h6001), xy(2, 1), 1'b1);
        send(1, mk(2'b10, 0, 1, 48'h6101), xy(0, 1), 1'b1);
        send(0, mk(2'b00, 2, 1, 48'h6002), xy(2, 1), 1'b1);
        send(1, mk(2'b00, 0, 1, 48'h6102), xy(0, 1), 1'b1);
        drain(0, 1);
        check("pre_rst_credit", 64'(credit_out[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_credit", 64'(credit_out), 64'd0);
        check("mid_rst_valid", 64'(req_valid), 64'd0);
        check("mid_rst_route", 64'(req_route), 64'd0);
        sb[0].delete();
        sb[1].delete();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 64'(req_valid), 64'd0);
        send(1, mk(2'b11, 1, 2, 48'h7001), xy(1, 2), 1'b1);
        drain(1, 1);
        check("post_rst_ovf", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
